// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared types and constants for the SCCB write master
//
// Holds the transaction FSM state encoding, the default sensor slave
// address and the bus timing constants used by sccb_wr_master.
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND_BYTE,
        ACK,
        STOP,
        DONE
    } sccb_state_e;

    // Default 7-bit sensor address; first byte on the wire is {addr, 1'b0}
    localparam logic [6:0] SCCB_DEV_ADDR = 7'h3C;

    // Every bit (and the START/STOP conditions) is split into four quarters
    localparam int QUARTERS_PER_BIT = 4;

    // Bit periods of released, idle bus appended after the STOP condition.
    // Together with START (1), four bytes plus ACK (36) and STOP (1) this
    // gives the fixed 44-bit transaction length and guarantees bus-free
    // time between back-to-back writes.
    localparam int STOP_IDLE_BITS = 6;

endpackage

// File: rtl/sccb_tick_gen.sv
// rtl/sccb_tick_gen.sv - quarter-SCL tick divider with synchronous restart
//
// Ports:
//   sys_clk   - clock
//   sys_rst_n - asynchronous active-low reset (counter to 0)
//   restart   - synchronous restart: counter forced to 0, no tick this cycle
//   tick      - one-cycle pulse every QDIV sys_clk cycles after restart ends
module sccb_tick_gen #(
    parameter int QDIV = 50
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/sccb_wr_master.sv
// rtl/sccb_wr_master.sv - SCCB three-phase register write master
//
// Writes one 8-bit value to a 16-bit sensor register per cfg_start:
// START, {DEV_ADDR,0}, REG_ADDR[15:8], REG_ADDR[7:0], REG_VAL, STOP.
//
// Ports:
//   sys_clk    - clock
//   sys_rst_n  - asynchronous active-low reset
//   cfg_start  - write request pulse, accepted only in IDLE
//   cfg_data   - {REG_ADDR[15:0], REG_VAL[7:0]}, latched at accept
//   cfg_end    - one-cycle pulse when the write has completed
//   busy       - transaction in progress
//   ack_err    - NACK seen in the last transaction
//   scl        - SCCB clock, push-pull, idle high
//   sda        - open-drain data, driven low or released
//
// Build option: define SCCB_ACK_CHECK_EN to sample the slave ACK and abort
// to STOP on a NACK; otherwise the ACK slot is ignored and ack_err is 0.
module sccb_wr_master
    import sccb_pkg::*;
#(
    parameter int         SYS_CLK_FREQ = 50_000_000,
    parameter int         SCL_FREQ     = 250_000,
    parameter logic [6:0] DEV_ADDR     = SCCB_DEV_ADDR
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cfg_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);

    localparam int         QDIV   = SYS_CLK_FREQ / (4 * SCL_FREQ);
    localparam logic [1:0] Q_LAST = 2'(QUARTERS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_IDLE_BITS);

    sccb_state_e state, state_nx;
    logic [1:0]  qtr, qtr_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [1:0]  byte_idx, byte_idx_nx;
    logic [2:0]  stop_cnt, stop_cnt_nx;
    logic [31:0] shreg, shreg_nx;
    logic        scl_c, sda_oe_c;
    logic        scl_q, sda_oe_q;
    logic        tick, bit_end, ack_abort;

    // The divider is held at 0 while idle, so the accepting edge starts
    // the first quarter of START from a clean count.
    sccb_tick_gen #(.QDIV(QDIV)) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .restart   (state == IDLE),
        .tick      (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            qtr      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            stop_cnt <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            qtr      <= qtr_nx;
            bit_idx  <= bit_idx_nx;
            byte_idx <= byte_idx_nx;
            stop_cnt <= stop_cnt_nx;
            shreg    <= shreg_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        qtr_nx      = qtr;
        bit_idx_nx  = bit_idx;
        byte_idx_nx = byte_idx;
        stop_cnt_nx = stop_cnt;
        shreg_nx    = shreg;
        scl_c       = 1'b1;
        sda_oe_c    = 1'b0;
        bit_end     = tick && (qtr == Q_LAST);

        if (tick) begin
            qtr_nx = qtr + 2'd1;
        end

        case (state)
            IDLE: begin
                qtr_nx = '0;
                if (cfg_start) begin
                    state_nx    = START;
                    shreg_nx    = {DEV_ADDR, 1'b0, cfg_data};
                    bit_idx_nx  = '0;
                    byte_idx_nx = '0;
                    stop_cnt_nx = '0;
                end
            end
            START: begin
                sda_oe_c = 1'b1;
                scl_c    = (qtr < 2'd2);
                if (bit_end) begin
                    state_nx = SEND_BYTE;
                end
            end
            SEND_BYTE: begin
                // Data is set up for the whole bit; scl is low in quarters
                // 0 and 3, so the only sda transition falls in quarter 0.
                scl_c    = (qtr == 2'd1) || (qtr == 2'd2);
                sda_oe_c = !shreg[31];
                if (bit_end) begin
                    shreg_nx   = {shreg[30:0], 1'b0};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = ACK;
                    end
                end
            end
            ACK: begin
                scl_c = (qtr == 2'd1) || (qtr == 2'd2);
                if (bit_end) begin
                    if ((byte_idx == 2'd3) || ack_abort) begin
                        state_nx = STOP;
                    end else begin
                        byte_idx_nx = byte_idx + 2'd1;
                        state_nx    = SEND_BYTE;
                    end
                end
            end
            STOP: begin
                // First bit period is the STOP condition itself; the rest
                // is bus-free time with both lines idle.
                if (stop_cnt == 3'd0) begin
                    scl_c    = (qtr != 2'd0);
                    sda_oe_c = (qtr < 2'd2);
                end
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_nx = DONE;
                    end else begin
                        stop_cnt_nx = stop_cnt + 3'd1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus lines come straight from flops so scl/sda never glitch on
    // multi-bit quarter-counter transitions.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
        end else begin
            scl_q    <= scl_c;
            sda_oe_q <= sda_oe_c;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic accept;
    logic ack_sample_d;
    logic ack_err_q;

    assign accept = (state == IDLE) && cfg_start;

    // The bus lags the FSM by one flop, so the sample strobe is delayed
    // by one cycle to land on the last cycle of quarter 1 on the wire.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ack_sample_d <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            ack_sample_d <= (state == ACK) && tick && (qtr == 2'd1);
            if (accept) begin
                ack_err_q <= 1'b0;
            end else if (ack_sample_d && sda) begin
                ack_err_q <= 1'b1;
            end
        end
    end

    assign ack_err   = ack_err_q;
    assign ack_abort = ack_err_q;
`else
    assign ack_err   = 1'b0;
    assign ack_abort = 1'b0;
`endif

    assign scl     = scl_q;
    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign busy    = (state != IDLE) && (state != DONE);
    assign cfg_end = (state == DONE);

endmodule

// File: tb/tb_sccb_wr_master.sv
// tb/tb_sccb_wr_master.sv - self-checking bench for sccb_wr_master
module tb_sccb_wr_master;

    localparam int         SYS_F   = 1_000_000;
    localparam int         SCL_F   = 250_000;
    localparam int         QDIV    = SYS_F / (4 * SCL_F);
    localparam int         TXN_CYC = 176 * QDIV;
    localparam logic [6:0] DEV     = 7'h3C;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        cfg_start = 1'b0;
    logic [23:0] cfg_data  = '0;
    logic        cfg_end, busy, ack_err, scl;
    wire         sda;
    logic        slv_drv   = 1'b0;

    pullup (sda);
    assign sda = slv_drv ? 1'b0 : 1'bz;

    sccb_wr_master #(
        .SYS_CLK_FREQ (SYS_F),
        .SCL_FREQ     (SCL_F),
        .DEV_ADDR     (DEV)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_end   (cfg_end),
        .busy      (busy),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda       (sda)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_end = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) if (cfg_end) n_end <= n_end + 1;

    // Bus monitor and slave model
    logic [7:0] rx_q[$];
    logic [7:0] shift_in = '0;
    int  bit_cnt = 0, byte_cnt = 0, n_start = 0, n_stop = 0, frame_err = 0;
    int  nack_at = -1, exp_frame_bytes = 4;
    bit  in_frame = 0;
    logic sda_p = 1'b1, scl_p = 1'b1;

    always @(sda or scl or sys_rst_n) begin
        if (!sys_rst_n) begin
            in_frame = 0;
            bit_cnt  = 0;
            slv_drv  = 1'b0;
        end else if (scl === 1'b1 && scl_p === 1'b1 && sda !== sda_p) begin
            if (sda === 1'b0) begin
                if (in_frame) frame_err++;
                in_frame = 1;
                bit_cnt  = 0;
                byte_cnt = 0;
                n_start++;
            end else begin
                if (!in_frame || byte_cnt != exp_frame_bytes || bit_cnt != 1) frame_err++;
                in_frame = 0;
                n_stop++;
            end
        end else if (scl === 1'b1 && scl_p === 1'b0) begin
            if (in_frame) begin
                if (bit_cnt < 8) shift_in = {shift_in[6:0], (sda === 1'b0) ? 1'b0 : 1'b1};
                bit_cnt++;
            end
        end else if (scl === 1'b0 && scl_p === 1'b1) begin
            if (in_frame) begin
                if (bit_cnt == 8) begin
                    rx_q.push_back(shift_in);
                    slv_drv = (byte_cnt != nack_at);
                end else if (bit_cnt == 9) begin
                    slv_drv  = 1'b0;
                    bit_cnt  = 0;
                    byte_cnt++;
                end
            end
        end
        sda_p = sda;
        scl_p = scl;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: the four bytes on the wire, from plain arithmetic on the request
    function automatic logic [31:0] ref_bytes(input logic [23:0] d);
        int b0, b1, b2, b3;
        b0 = int'(DEV) * 2;
        b1 = int'(d) / 65536;
        b2 = (int'(d) / 256) % 256;
        b3 = int'(d) % 256;
        return 32'((b0 << 24) | (b1 << 16) | (b2 << 8) | b3);
    endfunction

    task automatic get_bytes(output logic [31:0] v, output int n);
        n = rx_q.size();
        v = '0;
        while (rx_q.size() > 0) v = {v[23:0], rx_q.pop_front()};
    endtask

    task automatic start_write(input logic [23:0] d, output int acc);
        @(negedge sys_clk);
        cfg_data  = d;
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        acc = cyc;
        check("accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_end(input int bound, input bit junk, input bit hold,
                            input int poke, output int ecyc);
        ecyc = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge sys_clk);
            if (cfg_end) begin
                ecyc = cyc;
                break;
            end
            cfg_start = hold || (k == poke);
            if (k == poke) cfg_data = ~cfg_data;
            else if (junk) cfg_data = 24'($urandom);
        end
        if (ecyc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL cfg_end_timeout: no cfg_end within %0d cycles", bound);
        end
    endtask

    task automatic run_txn(input string nm, input logic [23:0] d, input logic [31:0] exp,
                           input bit junk, input int poke);
        int acc, ecyc, n0, s0, f0, n;
        logic [31:0] v;
        n0 = n_end; s0 = n_start; f0 = frame_err;
        start_write(d, acc);
        wait_end(TXN_CYC + 50, junk, 1'b0, poke, ecyc);
        check({nm, "_latency"}, 32'(ecyc - acc), 32'(TXN_CYC));
        cfg_start = 1'b0;
        @(negedge sys_clk);
        check({nm, "_end_width"}, 32'(cfg_end), 32'd0);
        check({nm, "_busy_after"}, 32'(busy), 32'd0);
        get_bytes(v, n);
        check({nm, "_nbytes"}, 32'(n), 32'd4);
        check({nm, "_bytes"}, v, exp);
        check({nm, "_n_end"}, 32'(n_end - n0), 32'd1);
        check({nm, "_n_start"}, 32'(n_start - s0), 32'd1);
        check({nm, "_frame"}, 32'(frame_err - f0), 32'd0);
        check({nm, "_ack_err"}, 32'(ack_err), 32'd0);
    endtask

    typedef struct {
        logic [23:0] data;
        logic [7:0]  b1, b2, b3;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int acc, ecyc, n, n0, s0, f0, prev_end;
        logic [31:0] v, exp;
        logic [23:0] d;

        tbl[0] = '{data: 24'h300882, b1: 8'h30, b2: 8'h08, b3: 8'h82};
        tbl[1] = '{data: 24'h000000, b1: 8'h00, b2: 8'h00, b3: 8'h00};
        tbl[2] = '{data: 24'hFFFFFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF};
        tbl[3] = '{data: 24'hA55A0F, b1: 8'hA5, b2: 8'h5A, b3: 8'h0F};
        tbl[4] = '{data: 24'h01807E, b1: 8'h01, b2: 8'h80, b3: 8'h7E};

        // Reset state
        #2 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_end", 32'(cfg_end), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("idle_no_start", 32'(n_start), 32'd0);
        check("idle_scl", 32'(scl), 32'd1);
        check("idle_sda", 32'(sda), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven writes, expected bytes written out as constants
        foreach (tbl[i]) begin
            run_txn("tbl", tbl[i].data, {8'h78, tbl[i].b1, tbl[i].b2, tbl[i].b3}, 1'b0, -1);
        end

        // Second request while busy is dropped; first data goes out
        run_txn("busy_ignore", 24'h123456, {8'h78, 8'h12, 8'h34, 8'h56}, 1'b0, 98);
        s0 = n_start;
        repeat (TXN_CYC + 20) @(negedge sys_clk);
        check("busy_ignore_no_queue", 32'(n_start - s0), 32'd0);
        check("busy_ignore_idle", 32'(busy), 32'd0);

        // Random requests with cfg_data churning and stray cfg_start pulses
        for (int i = 0; i < 6; i++) begin
            d = 24'($urandom);
            run_txn("rand", d, ref_bytes(d), 1'b1, int'($urandom_range(5, 150)));
        end

        // Reset during the second byte
        start_write(24'h5AA5C3, acc);
        for (int k = 0; k < TXN_CYC && rx_q.size() < 1; k++) @(negedge sys_clk);
        check("mid_byte1_seen", 32'(rx_q.size()), 32'd1);
        repeat (6 * QDIV) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_scl", 32'(scl), 32'd1);
        check("mid_rst_sda", 32'(sda), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cfg_end", 32'(cfg_end), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        rx_q.delete();
        n0 = n_end; s0 = n_start;
        repeat (TXN_CYC + 20) @(negedge sys_clk);
        check("mid_rst_no_end", 32'(n_end - n0), 32'd0);
        check("mid_rst_quiet", 32'(n_start - s0), 32'd0);
        check("mid_rst_scl_idle", 32'(scl), 32'd1);

`ifdef SCCB_ACK_CHECK_EN
        // Slave NACKs the address byte: abort to STOP, still end the write
        nack_at = 0;
        exp_frame_bytes = 1;
        n0 = n_end; f0 = frame_err; s0 = n_stop;
        start_write(24'h300882, acc);
        wait_end(TXN_CYC + 50, 1'b0, 1'b0, -1, ecyc);
        check("nack_ack_err", 32'(ack_err), 32'd1);
        @(negedge sys_clk);
        check("nack_end_width", 32'(cfg_end), 32'd0);
        get_bytes(v, n);
        check("nack_nbytes", 32'(n), 32'd1);
        check("nack_byte0", v, 32'h78);
        check("nack_stop", 32'(n_stop - s0), 32'd1);
        check("nack_frame", 32'(frame_err - f0), 32'd0);
        check("nack_n_end", 32'(n_end - n0), 32'd1);
        repeat (10) @(negedge sys_clk);
        check("nack_ack_err_hold", 32'(ack_err), 32'd1);
        nack_at = -1;
        exp_frame_bytes = 4;
        start_write(24'h300882, acc);
        check("nack_clear_on_accept", 32'(ack_err), 32'd0);
        wait_end(TXN_CYC + 50, 1'b0, 1'b0, -1, ecyc);
        check("nack_next_latency", 32'(ecyc - acc), 32'(TXN_CYC));
        check("nack_next_ack_err", 32'(ack_err), 32'd0);
        @(negedge sys_clk);
        get_bytes(v, n);
        check("nack_next_bytes", v, 32'h7830_0882);
`else
        // Without ACK checking a NACK changes nothing
        nack_at = 1;
        run_txn("nack_ignored", 24'h0A0B0C, {8'h78, 8'h0A, 8'h0B, 8'h0C}, 1'b0, -1);
        nack_at = -1;
`endif

        // Back-to-back writes with cfg_start held high throughout
        n0 = n_end; s0 = n_start; f0 = frame_err;
        prev_end = -1;
        d = 24'($urandom);
        @(negedge sys_clk);
        cfg_data  = d;
        cfg_start = 1'b1;
        for (int i = 0; i < 251; i++) begin
            acc = -1;
            for (int k = 0; k < 8; k++) begin
                @(negedge sys_clk);
                if (busy) begin
                    acc = cyc;
                    break;
                end
            end
            if (acc < 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b2b_accept_timeout: write %0d not accepted", i);
                break;
            end
            if (i > 0) check("b2b_gap", 32'(acc - prev_end), 32'd2);
            exp = ref_bytes(d);
            cfg_data = 24'($urandom);
            wait_end(TXN_CYC + 50, 1'b1, 1'b1, -1, ecyc);
            if (ecyc < 0) break;
            prev_end = ecyc;
            check("b2b_latency", 32'(ecyc - acc), 32'(TXN_CYC));
            get_bytes(v, n);
            check("b2b_bytes", v, exp);
            d = 24'($urandom);
            cfg_data = d;
        end
        cfg_start = 1'b0;
        repeat (TXN_CYC + 20) @(negedge sys_clk);
        check("b2b_n_end", 32'(n_end - n0), 32'd251);
        check("b2b_n_start", 32'(n_start - s0), 32'd251);
        check("b2b_frame", 32'(frame_err - f0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sccb_wr_master.md
SCCB_WR_MASTER -- requirements
Module: sccb_wr_master

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-002 SHALL have parameter SCL_FREQ, default 250_000, SCL frequency in Hz.
REQ-003 SHALL have parameter DEV_ADDR, default 7'h3C, 7-bit sensor slave address; the first byte sent is {DEV_ADDR,1'b0} = 8'h78.
REQ-004 SHALL have port sys_clk, input, 1 bit: clock.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_start, input, 1 bit: single-register write request pulse.
REQ-007 SHALL have port cfg_data, input, 24 bits: {REG_ADDR[15:0], REG_VAL[7:0]}.
REQ-008 SHALL have port cfg_end, output, 1 bit: one-cycle pulse marking write complete.
REQ-009 SHALL have port busy, output, 1 bit: transaction in progress.
REQ-010 SHALL have port ack_err, output, 1 bit: NACK seen in the last transaction.
REQ-011 SHALL have port scl, output, 1 bit: SCCB clock, push-pull, idle high.
REQ-012 SHALL have port sda, inout, 1 bit: open-drain data line, driven 0 or released (Z) only.

Function
REQ-013 SHALL derive a quarter-SCL tick every QDIV = SYS_CLK_FREQ/(4*SCL_FREQ) sys_clk cycles (default 50); each bit occupies 4 quarters.
REQ-014 SHALL accept cfg_start only in IDLE, latch cfg_data, assert busy on the next edge, and restart the tick counter at 0.
REQ-015 SHALL ignore cfg_start while busy = 1; no queuing.
REQ-016 SHALL use FSM states IDLE, START, SEND_BYTE, ACK, STOP, DONE.
REQ-017 START (4 quarters): sda driven low at quarter 0 while scl is high; scl goes low at quarter 2.
REQ-018 SEND_BYTE: MSB first; sda changes only in quarter 0 while scl is low; scl is high in quarters 1-2 and low in quarter 3.
REQ-019 Byte order SHALL be: 8'h78, REG_ADDR[15:8], REG_ADDR[7:0], REG_VAL; each byte is followed by one ACK slot with sda released.
REQ-020 STOP (4 quarters): sda low at quarter 0, scl high at quarter 1, sda released at quarter 2.
REQ-021 DONE SHALL pulse cfg_end for exactly 1 cycle, clear busy in the same cycle, then return to IDLE.
REQ-022 A full transaction is 44 bit periods = 176 quarters; the cfg_end rising edge SHALL occur exactly 176*QDIV cycles (8800 at default) after the accepting edge.
REQ-023 A cfg_start coincident with the cfg_end cycle SHALL be ignored; it is accepted from the following cycle onward.
REQ-024 Latched data SHALL be held stable for the whole transaction, independent of cfg_data changes.

Reset
REQ-025 On sys_rst_n low, at any time including mid-transaction: state = IDLE, scl = 1, sda released, cfg_end = 0, busy = 0, ack_err = 0, tick counter = 0.
REQ-026 After reset release, no bus activity SHALL occur until the first cfg_start.

Configuration
REQ-027 With SCCB_ACK_CHECK_EN defined: sda SHALL be sampled at the end of quarter 1 of each ACK slot.
REQ-028 With SCCB_ACK_CHECK_EN defined: a sampled 1 SHALL set ack_err, skip the remaining bytes, go directly to STOP, and still pulse cfg_end.
REQ-029 With SCCB_ACK_CHECK_EN defined: ack_err SHALL clear on the next accepted cfg_start.
REQ-030 Without SCCB_ACK_CHECK_EN: the ACK slot is a don't-care bit, ack_err is tied to 0, and timing always follows REQ-022.

Structure
REQ-031 Package sccb_pkg SHALL hold the FSM state enum, the default DEV_ADDR, and the quarters-per-bit constant (4).
REQ-032 Sub-module sccb_tick_gen SHALL implement the QDIV quarter-tick divider with a synchronous restart input.

Verification
REQ-033 Write check: reset, cfg_start with cfg_data = 24'h3008_82, slave model ACKs -> bytes decoded 78, 30, 08, 82; cfg_end exactly once, 8800 cycles after accept.
REQ-034 Busy ignore: second cfg_start 100 cycles after the first, with different data -> only one transaction on the bus; the latched first data is sent.
REQ-035 Reset mid-transaction: assert sys_rst_n low during byte 2 -> scl = 1, sda = Z, busy = 0 immediately, and no cfg_end.
REQ-036 NACK with SCCB_ACK_CHECK_EN: slave NACKs byte 1 -> ack_err = 1, STOP follows, cfg_end pulses; the next accepted cfg_start clears ack_err.
REQ-037 Timing protocol check: over 251 back-to-back writes, sda never changes while scl = 1 except at START/STOP; 251 cfg_end pulses observed.
